// File: rtl/mem_ctrl_pkg.sv
// Purpose: shared types for the memory arbiter/controller (FSM states, access op).
// Latency: n/a (types and a width helper only).
// Backpressure: n/a.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        WAIT   = 3'd2,
        ACCESS = 3'd3,
        DONE   = 3'd4
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    // Bits needed to hold an index in [0, n-1]; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_prio_arbiter.sv
// Purpose: fixed-priority encoder, lowest request index wins.
// Latency: combinational, zero cycles.
// Backpressure: none; the caller decides when to sample the grant.
// Ports: req (request vector) -> grant (one-hot), idx (binary index of grant), any (some request present).
module mem_prio_arbiter
    import mem_ctrl_pkg::*;
#(
    parameter  int NUM_CH = 2,
    localparam int IDX_W  = idx_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  idx,
    output logic              any
);

    logic hit;

    always_comb begin
        grant = '0;
        idx   = '0;
        hit   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (req[i] && !hit) begin
                grant[i] = 1'b1;
                idx      = IDX_W'(i);
                hit      = 1'b1;
            end
        end
    end

    assign any = hit;

endmodule

// File: rtl/mem_arbiter_ctrl.sv
// Purpose: arbitrates NUM_CH requesters onto one memory bus, one access at a time.
// Latency: grant 1 cycle after the request is sampled, done 3 cycles after with a free bus and immediate ack.
// Backpressure: bus_full holds the access in WAIT; bus_ack ends ACCESS; requests are ignored until back in IDLE.
// Ports: clk/rst (sync, active high); ch_read/ch_write/ch_addr/ch_wdata per-channel requests;
//        ch_grant/ch_done/ch_err one-hot pulses, ch_rdata shared read data; bus_* memory bus; state for debug.
// Optional: define MEMCTRL_TIMEOUT_EN to abort WAIT/ACCESS after TIMEOUT_CYCLES cycles with ch_err.
module mem_arbiter_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int NUM_CH         = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_read,
    input  logic [NUM_CH-1:0]        ch_write,
    input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
    input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
    output logic [NUM_CH-1:0]        ch_grant,
    output logic [NUM_CH-1:0]        ch_done,
    output logic [NUM_CH-1:0]        ch_err,
    output logic [DATA_W-1:0]        ch_rdata,
    input  logic                     bus_full,
    input  logic                     bus_ack,
    input  logic [DATA_W-1:0]        bus_rdata,
    output logic [ADDR_W-1:0]        bus_addr,
    output logic [DATA_W-1:0]        bus_wdata,
    output logic                     bus_read,
    output logic                     bus_write,
    output logic [2:0]               state
);

    localparam int IDX_W = idx_width(NUM_CH);

    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] arb_grant;
    logic [IDX_W-1:0]  arb_idx;
    logic              arb_any;

    state_t            state_q;
    op_t               op_q;
    logic [NUM_CH-1:0] sel_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              is_read;

    assign req     = ch_read | ch_write;
    assign is_read = (op_q == OP_READ);
    assign state   = state_q;

    mem_prio_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req   (req),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

`ifdef MEMCTRL_TIMEOUT_EN
    // Counter only has to reach TIMEOUT_CYCLES-1: the abort fires on that cycle's edge.
    localparam int                CNT_W    = idx_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] tmo_cnt;
`else
    assign ch_err = '0;
    // Keeps the watchdog limit referenced while the watchdog is compiled out.
    if (TIMEOUT_CYCLES < 1) begin : g_tmo_param_ref
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= OP_READ;
            sel_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ch_grant  <= '0;
            ch_done   <= '0;
            ch_rdata  <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
`ifdef MEMCTRL_TIMEOUT_EN
            ch_err    <= '0;
            tmo_cnt   <= '0;
`endif
        end else begin
            // Pulses default low; only the transition edges raise them.
            ch_grant <= '0;
            ch_done  <= '0;
`ifdef MEMCTRL_TIMEOUT_EN
            ch_err   <= '0;
`endif
            case (state_q)
                IDLE: begin
                    if (arb_any) begin
                        sel_q    <= arb_grant;
                        addr_q   <= ch_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
                        wdata_q  <= ch_wdata[int'(arb_idx)*DATA_W +: DATA_W];
                        // Read wins when a channel raises both strobes.
                        op_q     <= ch_read[arb_idx] ? OP_READ : OP_WRITE;
                        ch_grant <= arb_grant;
                        state_q  <= REQ;
                    end
                end

                REQ, WAIT: begin
                    if (!bus_full) begin
                        state_q   <= ACCESS;
                        bus_addr  <= addr_q;
                        bus_read  <= is_read;
                        bus_write <= !is_read;
                        bus_wdata <= is_read ? '0 : wdata_q;
`ifdef MEMCTRL_TIMEOUT_EN
                        tmo_cnt   <= '0;
`endif
                    end else if (state_q == REQ) begin
                        state_q <= WAIT;
`ifdef MEMCTRL_TIMEOUT_EN
                        tmo_cnt <= '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state_q <= DONE;
                        ch_done <= sel_q;
                        ch_err  <= sel_q;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    end
                end

                ACCESS: begin
                    if (bus_ack) begin
                        bus_addr  <= '0;
                        bus_wdata <= '0;
                        bus_read  <= 1'b0;
                        bus_write <= 1'b0;
                        if (is_read) begin
                            ch_rdata <= bus_rdata;
                        end
                        ch_done <= sel_q;
                        state_q <= DONE;
`ifdef MEMCTRL_TIMEOUT_EN
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Abort: strobes drop, ch_rdata keeps its previous value.
                        bus_addr  <= '0;
                        bus_wdata <= '0;
                        bus_read  <= 1'b0;
                        bus_write <= 1'b0;
                        ch_done   <= sel_q;
                        ch_err    <= sel_q;
                        state_q   <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
`endif
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_arbiter_ctrl.md
Name: mem_arbiter_ctrl

Overview:
Parametrised successor to the single-port data/instruction memory controller. Arbitrates NUM_CH requesters (ch0 = data memory, ch1 = instruction fetch, more optional) onto one memory bus with a busy/ack handshake. Latches one request at a time, waits out bus_full, drives the bus access and returns a one-cycle completion pulse to the winning channel. Sits between the RV32I core's fetch/load-store units and the bus wrapper.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
NUM_CH, 2, requester channels; lower index = higher priority
TIMEOUT_CYCLES, 255, watchdog limit (used only with MEMCTRL_TIMEOUT_EN)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ch_read  in  NUM_CH  per-channel read request (level)
ch_write  in  NUM_CH  per-channel write request (level)
ch_addr  in  NUM_CH*ADDR_W  per-channel address, ch i at [i*ADDR_W +: ADDR_W]
ch_wdata  in  NUM_CH*DATA_W  per-channel write data
ch_grant  out  NUM_CH  one-hot, 1-cycle pulse: request latched
ch_done  out  NUM_CH  one-hot, 1-cycle pulse: access complete
ch_err  out  NUM_CH  one-hot, 1-cycle pulse with ch_done: access aborted
ch_rdata  out  DATA_W  read data, shared, valid while ch_done is high
bus_full  in  1  bus busy; no new access may start
bus_ack  in  1  bus accepted the write / returned the read data
bus_rdata  in  DATA_W  bus read data
bus_addr  out  ADDR_W  access address
bus_wdata  out  DATA_W  write data
bus_read  out  1  read strobe
bus_write  out  1  write strobe
state  out  3  current FSM state, for debug/bench

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst). The polarity and synchronicity are fixed.
- Reset values: state=IDLE. All ch_* outputs, all bus_* outputs and ch_rdata are 0.
- Reset mid-operation: the transaction is abandoned. Outputs are 0 after the reset edge. No done or err pulse is issued.
- A channel requests when ch_read|ch_write is high. If both are high, read wins. If neither is high, there is no request.
- IDLE: select the lowest-indexed requesting channel. Latch its addr, wdata and op. Pulse ch_grant[sel]. Go to REQ. With no request, stay in IDLE.
- After the grant, request inputs are ignored until the next IDLE.
- REQ: if bus_full, go to WAIT; otherwise go to ACCESS.
- WAIT: stay while bus_full. When bus_full falls, go to ACCESS.
- ACCESS: drive bus_addr, plus bus_read or bus_write, plus bus_wdata (writes only). Hold all of these until bus_ack is sampled high, then go to DONE.
- On a read, bus_rdata is captured into ch_rdata on the ack edge.
- DONE: pulse ch_done[sel] for one cycle, then go to IDLE. No new grant is issued in DONE.
- Outside ACCESS: bus_addr, bus_wdata, bus_read and bus_write are all 0.
- ch_rdata holds its last read value until the next read completes.
- bus_ack outside ACCESS is ignored.
- Latency with no contention and ack on the first ACCESS cycle: ch_grant is high in the cycle after the request is sampled; ch_done is high 3 cycles after the sampling edge.
- Fairness: fixed priority. A channel may starve while a higher-priority channel requests continuously. This is accepted.

Optional Feature:
Macro MEMCTRL_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT and on entry to ACCESS, and increments every cycle in those states.
  - On reaching TIMEOUT_CYCLES without leaving the state, go to DONE with ch_err[sel]=1 alongside ch_done[sel].
  - ch_rdata is unchanged on an abort, and bus strobes drop.
- Undefined: no counter. ch_err is tied to 0. WAIT and ACCESS may last indefinitely.

Decomposition:
- Package mem_ctrl_pkg:
  - state_t enum: IDLE=0, REQ=1, WAIT=2, ACCESS=3, DONE=4
  - op_t enum: OP_READ, OP_WRITE
- One sub-module: mem_prio_arbiter, parametrised by NUM_CH. Combinational fixed-priority encoder taking the request vector and producing a one-hot grant plus a binary index.

Test Plan:
1. Reset: hold rst 2 cycles with ch_read=2'b01 → state=IDLE and all outputs 0 throughout; first grant only after rst falls.
2. Simple read: ch0 read, addr 0x10, bus_full=0, bus_rdata=0xDEADBEEF, ack on first ACCESS cycle → ch_grant=01 at +1, bus_read=1 and bus_addr=0x10 in ACCESS, ch_done=01 with ch_rdata=0xDEADBEEF at +3.
3. Priority and read-over-write: ch0 read+write, ch1 read, same cycle → ch0 granted as a read; ch1 granted on the IDLE following ch0's DONE.
4. Busy bus: ch1 write, wdata 0x55, bus_full high for 4 cycles → state REQ→WAIT×4→ACCESS; bus_write=0 while waiting; ch_done=10 after ack.
5. Idle and mid-op reset: no requests for 10 cycles → stays IDLE with bus strobes 0; then rst asserted in ACCESS → IDLE next edge, no ch_done.
6. MEMCTRL_TIMEOUT_EN with TIMEOUT_CYCLES=8 and bus_ack never asserted → ch_done and ch_err pulse after 8 ACCESS cycles; ch_rdata unchanged.
